// File: rtl/exu_wbck.sv
// Write-back arbiter for the EXU: merges ALU and long-pipe results onto the single
// register-file write port and tracks long-pipe destinations still in flight.
module exu_wbck #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   alu_wbck_valid,
    output logic                   alu_wbck_ready,
    input  logic [RFIDX_WIDTH-1:0] alu_wbck_idx,
    input  logic [XLEN-1:0]        alu_wbck_data,

    input  logic                   lng_wbck_valid,
    output logic                   lng_wbck_ready,
    input  logic [RFIDX_WIDTH-1:0] lng_wbck_idx,
    input  logic [XLEN-1:0]        lng_wbck_data,

    input  logic                   disp_lng_valid,
    input  logic [RFIDX_WIDTH-1:0] disp_lng_idx,
    input  logic [RFIDX_WIDTH-1:0] disp_src1_idx,
    input  logic [RFIDX_WIDTH-1:0] disp_src2_idx,
    input  logic [RFIDX_WIDTH-1:0] disp_dst_idx,
    output logic                   disp_hazard,

    output logic                   wbck_dest_ena,
    output logic [RFIDX_WIDTH-1:0] wbck_dest_idx,
    output logic [XLEN-1:0]        wbck_dest_data
);

    localparam int RFREG_NUM = 1 << RFIDX_WIDTH;

    logic [RFIDX_WIDTH-1:0] fifo_idx  [2];
    logic [XLEN-1:0]        fifo_data [2];
    logic [1:0]             fifo_cnt;
    logic                   fifo_wptr;
    logic                   fifo_rptr;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_nempty;

    logic                   sel_valid;
    logic [RFIDX_WIDTH-1:0] sel_idx;
    logic [XLEN-1:0]        sel_data;

    logic [RFREG_NUM-1:0]   pend;
    logic [RFREG_NUM-1:0]   pend_nxt;

    // No same-cycle bypass: ready depends only on the registered count.
    assign lng_wbck_ready = (fifo_cnt != 2'd2);
    assign fifo_push      = lng_wbck_valid & lng_wbck_ready;
    assign fifo_nempty    = (fifo_cnt != 2'd0);
    assign fifo_pop       = fifo_nempty;

    // Buffered long-pipe results are older than any ALU result, so they always win.
    always_comb begin
        sel_valid      = 1'b0;
        sel_idx        = '0;
        sel_data       = '0;
        alu_wbck_ready = 1'b1;
        if (fifo_nempty) begin
            sel_valid      = 1'b1;
            sel_idx        = fifo_idx[fifo_rptr];
            sel_data       = fifo_data[fifo_rptr];
            alu_wbck_ready = 1'b0;
        end else if (alu_wbck_valid) begin
            sel_valid = 1'b1;
            sel_idx   = alu_wbck_idx;
            sel_data  = alu_wbck_data;
        end
    end

    assign wbck_dest_ena  = sel_valid & (sel_idx != '0);
    assign wbck_dest_idx  = sel_idx;
    assign wbck_dest_data = sel_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_idx[0]  <= '0;
            fifo_idx[1]  <= '0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_cnt     <= 2'd0;
            fifo_wptr    <= 1'b0;
            fifo_rptr    <= 1'b0;
        end else begin
            if (fifo_push) begin
                fifo_idx[fifo_wptr]  <= lng_wbck_idx;
                fifo_data[fifo_wptr] <= lng_wbck_data;
                fifo_wptr            <= ~fifo_wptr;
            end
            if (fifo_pop) begin
                fifo_rptr <= ~fifo_rptr;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // A dispatch setting the same index that is being retired wins: that op is newer.
    always_comb begin
        pend_nxt = pend;
        if (fifo_pop) begin
            pend_nxt[sel_idx] = 1'b0;
        end
        if (disp_lng_valid && (disp_lng_idx != '0)) begin
            pend_nxt[disp_lng_idx] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign disp_hazard = pend[disp_src1_idx] | pend[disp_src2_idx] | pend[disp_dst_idx];

endmodule

// File: tb/tb_exu_wbck.sv
// Directed self-checking bench for exu_wbck: arbitration, long-pipe buffering,
// pending-destination tracking and asynchronous reset.
module tb_exu_wbck;

    localparam int XLEN        = 32;
    localparam int RFIDX_WIDTH = 5;

    logic                   clk;
    logic                   rst;
    logic                   alu_wbck_valid;
    logic                   alu_wbck_ready;
    logic [RFIDX_WIDTH-1:0] alu_wbck_idx;
    logic [XLEN-1:0]        alu_wbck_data;
    logic                   lng_wbck_valid;
    logic                   lng_wbck_ready;
    logic [RFIDX_WIDTH-1:0] lng_wbck_idx;
    logic [XLEN-1:0]        lng_wbck_data;
    logic                   disp_lng_valid;
    logic [RFIDX_WIDTH-1:0] disp_lng_idx;
    logic [RFIDX_WIDTH-1:0] disp_src1_idx;
    logic [RFIDX_WIDTH-1:0] disp_src2_idx;
    logic [RFIDX_WIDTH-1:0] disp_dst_idx;
    logic                   disp_hazard;
    logic                   wbck_dest_ena;
    logic [RFIDX_WIDTH-1:0] wbck_dest_idx;
    logic [XLEN-1:0]        wbck_dest_data;

    int checks   = 0;
    int failures = 0;

    exu_wbck #(.XLEN(XLEN), .RFIDX_WIDTH(RFIDX_WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_wbck_valid (alu_wbck_valid),
        .alu_wbck_ready (alu_wbck_ready),
        .alu_wbck_idx   (alu_wbck_idx),
        .alu_wbck_data  (alu_wbck_data),
        .lng_wbck_valid (lng_wbck_valid),
        .lng_wbck_ready (lng_wbck_ready),
        .lng_wbck_idx   (lng_wbck_idx),
        .lng_wbck_data  (lng_wbck_data),
        .disp_lng_valid (disp_lng_valid),
        .disp_lng_idx   (disp_lng_idx),
        .disp_src1_idx  (disp_src1_idx),
        .disp_src2_idx  (disp_src2_idx),
        .disp_dst_idx   (disp_dst_idx),
        .disp_hazard    (disp_hazard),
        .wbck_dest_ena  (wbck_dest_ena),
        .wbck_dest_idx  (wbck_dest_idx),
        .wbck_dest_data (wbck_dest_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(
        input logic                   av, input logic [RFIDX_WIDTH-1:0] ai, input logic [XLEN-1:0] ad,
        input logic                   lv, input logic [RFIDX_WIDTH-1:0] li, input logic [XLEN-1:0] ld,
        input logic                   dv, input logic [RFIDX_WIDTH-1:0] di,
        input logic [RFIDX_WIDTH-1:0] s1, input logic [RFIDX_WIDTH-1:0] s2,
        input logic [RFIDX_WIDTH-1:0] dd
    );
        alu_wbck_valid = av; alu_wbck_idx = ai; alu_wbck_data = ad;
        lng_wbck_valid = lv; lng_wbck_idx = li; lng_wbck_data = ld;
        disp_lng_valid = dv; disp_lng_idx = di;
        disp_src1_idx  = s1; disp_src2_idx = s2; disp_dst_idx = dd;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkPort(input string tag, input logic ena, input logic [RFIDX_WIDTH-1:0] idx,
                             input logic [XLEN-1:0] data);
        checkOutput({tag, ".ena"},  64'(wbck_dest_ena),  64'(ena));
        checkOutput({tag, ".idx"},  64'(wbck_dest_idx),  64'(idx));
        checkOutput({tag, ".data"}, 64'(wbck_dest_data), 64'(data));
    endtask

    // Advance past the next rising edge; outputs are then sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst.lng_ready", 64'(lng_wbck_ready), 64'd1);
        checkOutput("rst.alu_ready", 64'(alu_wbck_ready), 64'd1);
        checkOutput("rst.hazard",    64'(disp_hazard),    64'd0);
        checkPort("rst.port", 1'b0, 5'd0, 32'd0);
        #1 rst = 1'b0;
        tick();

        // ALU result with empty FIFO goes straight to the port
        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("alu.ready", 64'(alu_wbck_ready), 64'd1);
        checkPort("alu.port", 1'b1, 5'd5, 32'hDEADBEEF);
        tick();

        // Long push at edge N preempts the ALU in cycle N+1
        applyStimulus(1, 5'd3, 32'h33, 1, 5'd7, 32'h11, 0, 0, 0, 0, 0);
        checkOutput("lng.push_ready", 64'(lng_wbck_ready), 64'd1);
        checkPort("lng.cycN", 1'b1, 5'd3, 32'h33);
        tick();
        applyStimulus(1, 5'd3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("lng.alu_stall", 64'(alu_wbck_ready), 64'd0);
        checkPort("lng.cycN1", 1'b1, 5'd7, 32'h11);
        tick();
        checkOutput("lng.alu_resume", 64'(alu_wbck_ready), 64'd1);
        checkPort("lng.cycN2", 1'b1, 5'd3, 32'h33);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkPort("lng.idle", 1'b0, 5'd0, 32'd0);

        // Three consecutive long results drain one per cycle, in order
        applyStimulus(0, 0, 0, 1, 5'd10, 32'hA0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd11, 32'hB0, 0, 0, 0, 0, 0);
        checkOutput("burst.ready_b", 64'(lng_wbck_ready), 64'd1);
        checkPort("burst.a", 1'b1, 5'd10, 32'hA0);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd12, 32'hC0, 0, 0, 0, 0, 0);
        checkOutput("burst.ready_c", 64'(lng_wbck_ready), 64'd1);
        checkPort("burst.b", 1'b1, 5'd11, 32'hB0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkPort("burst.c", 1'b1, 5'd12, 32'hC0);
        tick();
        checkPort("burst.empty", 1'b0, 5'd0, 32'd0);
        checkOutput("burst.alu_ready", 64'(alu_wbck_ready), 64'd1);

        // Pending idx 9 raises hazard until its long result is popped
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 0, 0);
        checkOutput("pend9.same_cycle", 64'(disp_hazard), 64'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0, 0);
        checkOutput("pend9.set", 64'(disp_hazard), 64'd1);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 5'd9, 0, 0);
        checkOutput("pend9.held", 64'(disp_hazard), 64'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0, 0);
        checkOutput("pend9.at_pop", 64'(disp_hazard), 64'd1);
        checkPort("pend9.port", 1'b1, 5'd9, 32'h99);
        tick();
        checkOutput("pend9.cleared", 64'(disp_hazard), 64'd0);

        // src2 and dst lookups; ALU write to a pending idx leaves it pending
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd12, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd12, 0);
        checkOutput("pend12.src2", 64'(disp_hazard), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd12);
        checkOutput("pend12.dst", 64'(disp_hazard), 64'd1);
        applyStimulus(1, 5'd12, 32'h1212, 0, 0, 0, 0, 0, 5'd13, 5'd11, 5'd12);
        checkOutput("pend12.other_src", 64'(disp_hazard), 64'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd13, 5'd11, 5'd12);
        checkOutput("pend12.alu_no_clear", 64'(disp_hazard), 64'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd13, 5'd11, 5'd10);
        checkOutput("pend12.miss", 64'(disp_hazard), 64'd0);
        applyStimulus(0, 0, 0, 1, 5'd12, 32'hC12, 0, 0, 0, 0, 5'd12);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd12);
        tick();
        checkOutput("pend12.cleared", 64'(disp_hazard), 64'd0);

        // Set wins over a same-cycle clear on idx 4
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 5'd4, 32'h44, 0, 0, 0, 0, 5'd4);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 0, 5'd4);
        checkPort("pend4.pop", 1'b1, 5'd4, 32'h44);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd4);
        checkOutput("pend4.set_wins", 64'(disp_hazard), 64'd1);
        applyStimulus(0, 0, 0, 1, 5'd4, 32'h45, 0, 0, 0, 0, 5'd4);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd4);
        tick();
        checkOutput("pend4.cleared", 64'(disp_hazard), 64'd0);

        // Index 0 is never pending; long write to x0 pops with ena=0
        applyStimulus(0, 0, 0, 1, 5'd0, 32'h55, 1, 5'd0, 0, 0, 0);
        tick();
        applyStimulus(1, 5'd6, 32'h66, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("x0.hazard", 64'(disp_hazard), 64'd0);
        checkOutput("x0.alu_stall", 64'(alu_wbck_ready), 64'd0);
        checkPort("x0.port", 1'b0, 5'd0, 32'h55);
        tick();
        checkOutput("x0.popped", 64'(alu_wbck_ready), 64'd1);
        checkPort("x0.alu_after", 1'b1, 5'd6, 32'h66);

        // Asynchronous reset with a buffered result and a pending bit
        applyStimulus(0, 0, 0, 1, 5'd21, 32'h77, 1, 5'd20, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd20, 0, 0);
        checkOutput("rst2.pre_hazard", 64'(disp_hazard), 64'd1);
        checkPort("rst2.pre_port", 1'b1, 5'd21, 32'h77);
        rst = 1'b1;
        #1;
        checkOutput("rst2.hazard",    64'(disp_hazard),    64'd0);
        checkOutput("rst2.lng_ready", 64'(lng_wbck_ready), 64'd1);
        checkOutput("rst2.alu_ready", 64'(alu_wbck_ready), 64'd1);
        checkPort("rst2.port", 1'b0, 5'd0, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        checkPort("rst2.no_partial", 1'b0, 5'd0, 32'd0);
        checkOutput("rst2.still_clear", 64'(disp_hazard), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
